// File: rtl/bus_cycle_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_cycle_responder_pkg
// Description : Shared types and helpers for the 68000 bus-cycle responder:
//               FSM state encoding, the latched region type, and the
//               region-priority decode applied at cycle start.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_cycle_responder_pkg;

  // Responder FSM states. The encoding width is fixed explicitly.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2,
    BERR = 2'd3
  } state_t;

  // Region captured when a cycle starts.
  typedef enum logic [2:0] {
    RGN_ROM  = 3'd0,
    RGN_RAM  = 3'd1,
    RGN_IO   = 3'd2,
    RGN_DRAM = 3'd3,
    RGN_NONE = 3'd4
  } region_t;

  // Select priority: ROM > on-chip RAM > IO > DRAM > none. On-chip RAM
  // beating DRAM resolves the overlapping window where the decoder raises
  // both selects.
  function automatic region_t selectRegion(input logic rom, input logic ram,
                                           input logic io, input logic dram);
    region_t r;
    if (rom)       r = RGN_ROM;
    else if (ram)  r = RGN_RAM;
    else if (io)   r = RGN_IO;
    else if (dram) r = RGN_DRAM;
    else           r = RGN_NONE;
    return r;
  endfunction

  // Internal regions are timed by the local wait counter; DRAM and
  // unselected cycles rely on the external acknowledge or the watchdog.
  function automatic logic isInternal(input region_t r);
    return (r == RGN_ROM) || (r == RGN_RAM) || (r == RGN_IO);
  endfunction

endpackage : bus_cycle_responder_pkg
`default_nettype wire

// File: rtl/bus_cycle_responder_timer.sv
`default_nettype none
// ============================================================================
// Module      : response_timer
// Description : Wait-state down-counter plus bus-error watchdog up-counter.
//               The wait counter is loaded with the region's wait value and
//               reports done when it reaches one; the watchdog is cleared at
//               cycle start and reports timeout one count before the limit,
//               so the FSM leaves WAIT exactly TIMEOUT edges after start.
// Revision    : 1.0 - initial release
// ============================================================================
module response_timer #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_loadValue,
  input  logic             i_clear,
  input  logic             i_enable,
  output logic             o_done,
  output logic             o_timeout
);

  localparam logic [WIDTH-1:0] c_one         = WIDTH'(1);
  localparam logic [WIDTH-1:0] c_timeoutLast = WIDTH'(TIMEOUT - 1);

  logic [WIDTH-1:0] r_waitCnt;
  logic [WIDTH-1:0] r_timeoutCnt;

  // Wait-state counter: load at start, count down while enabled, hold at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_waitCnt <= '0;
    end else if (i_load) begin
      r_waitCnt <= i_loadValue;
    end else if (i_enable && (r_waitCnt != '0)) begin
      r_waitCnt <= r_waitCnt - c_one;
    end
  end

  // Watchdog counter: cleared at start, counts every enabled edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timeoutCnt <= '0;
    end else if (i_clear) begin
      r_timeoutCnt <= '0;
    end else if (i_enable) begin
      r_timeoutCnt <= r_timeoutCnt + c_one;
    end
  end

  assign o_done    = (r_waitCnt == c_one);
  assign o_timeout = (r_timeoutCnt == c_timeoutLast);

endmodule : response_timer
`default_nettype wire

// File: rtl/bus_cycle_responder.sv
`default_nettype none
// ============================================================================
// Module      : bus_cycle_responder
// Description : Terminates 68000 bus cycles. Latches the decoded region at
//               the falling edge of AS_L, inserts the region's wait states
//               (or waits for the DRAM controller's DTACK), then drives
//               DTACK_L; unanswered cycles are ended with BERR_L by a
//               watchdog. Both outputs are registered from the next state,
//               so a zero-wait region is acknowledged on the start edge.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_cycle_responder #(
  parameter int ROM_WAIT     = 0,
  parameter int RAM_WAIT     = 1,
  parameter int IO_WAIT      = 3,
  parameter int BERR_TIMEOUT = 255
) (
  input  logic Clock,
  input  logic Reset_L,
  input  logic AS_L,
  input  logic UDS_L,
  input  logic LDS_L,
  input  logic OnChipRomSelect_H,
  input  logic OnChipRamSelect_H,
  input  logic IOSelect_H,
  input  logic DramSelect_H,
  input  logic DramDtack_L,
  output logic DtackOut_L,
  output logic BErr_L,
  output logic Busy_H
);

  import bus_cycle_responder_pkg::*;

  localparam int c_cntW = $clog2(BERR_TIMEOUT + 1);

  localparam logic [c_cntW-1:0] c_romWait = c_cntW'(ROM_WAIT);
  localparam logic [c_cntW-1:0] c_ramWait = c_cntW'(RAM_WAIT);
  localparam logic [c_cntW-1:0] c_ioWait  = c_cntW'(IO_WAIT);

  state_t             r_state;
  state_t             w_nextState;
  region_t            r_region;
  region_t            w_startRegion;
  logic               r_asPrev;
  logic [1:0]         r_unusedStrobes;
  logic               r_dtackL;
  logic               r_berrL;
  logic [c_cntW-1:0]  w_startWait;
  logic               w_start;
  logic               w_ackCond;
  logic               w_waitDone;
  logic               w_timeout;
  logic               w_timerEnable;
  logic               w_dtackNext;
  logic               w_berrNext;

  // A cycle starts on the first edge that sees AS_L low after seeing it high.
  assign w_start       = (r_state == IDLE) && !AS_L && r_asPrev;
  assign w_startRegion = selectRegion(OnChipRomSelect_H, OnChipRamSelect_H,
                                      IOSelect_H, DramSelect_H);
  assign w_timerEnable = (r_state == WAIT);

  // Wait value loaded at start; DRAM and unselected cycles load zero.
  always_comb begin
    w_startWait = '0;
    case (w_startRegion)
      RGN_ROM: w_startWait = c_romWait;
      RGN_RAM: w_startWait = c_ramWait;
      RGN_IO:  w_startWait = c_ioWait;
      default: w_startWait = '0;
    endcase
  end

  // Acknowledge condition while in WAIT, decided by the latched region only.
  always_comb begin
    w_ackCond = 1'b0;
    if (isInternal(r_region)) begin
      w_ackCond = w_waitDone;
    end else if (r_region == RGN_DRAM) begin
      w_ackCond = !DramDtack_L;
    end
  end

  response_timer #(
    .WIDTH   (c_cntW),
    .TIMEOUT (BERR_TIMEOUT)
  ) u_timer (
    .clk         (Clock),
    .rst_n       (Reset_L),
    .i_load      (w_start),
    .i_loadValue (w_startWait),
    .i_clear     (w_start),
    .i_enable    (w_timerEnable),
    .o_done      (w_waitDone),
    .o_timeout   (w_timeout)
  );

  // State register.
  always_ff @(posedge Clock or negedge Reset_L) begin
    if (!Reset_L) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: abort beats acknowledge, acknowledge beats timeout.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          if (isInternal(w_startRegion) && (w_startWait == '0)) begin
            w_nextState = ACK;
          end else begin
            w_nextState = WAIT;
          end
        end
      end
      WAIT: begin
        if (AS_L) begin
          w_nextState = IDLE;
        end else if (w_ackCond) begin
          w_nextState = ACK;
        end else if (w_timeout) begin
          w_nextState = BERR;
        end
      end
      ACK, BERR: begin
        if (AS_L) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Output decode from the next state, so the strobes register with it.
  always_comb begin
    w_dtackNext = 1'b1;
    w_berrNext  = 1'b1;
    case (w_nextState)
      ACK:     w_dtackNext = 1'b0;
      BERR:    w_berrNext  = 1'b0;
      default: begin
        w_dtackNext = 1'b1;
        w_berrNext  = 1'b1;
      end
    endcase
  end

  // Registered CPU strobes; reset forces both inactive immediately.
  always_ff @(posedge Clock or negedge Reset_L) begin
    if (!Reset_L) begin
      r_dtackL <= 1'b1;
      r_berrL  <= 1'b1;
    end else begin
      r_dtackL <= w_dtackNext;
      r_berrL  <= w_berrNext;
    end
  end

  // AS_L history, region latch, and data strobes captured for debug only.
  // AsPrev resets to "asserted" so a cycle in flight across reset is skipped.
  always_ff @(posedge Clock or negedge Reset_L) begin
    if (!Reset_L) begin
      r_asPrev        <= 1'b0;
      r_region        <= RGN_NONE;
      r_unusedStrobes <= 2'b11;
    end else begin
      r_asPrev <= AS_L;
      if (w_start) begin
        r_region        <= w_startRegion;
        r_unusedStrobes <= {UDS_L, LDS_L};
      end
    end
  end

  assign DtackOut_L = r_dtackL;
  assign BErr_L     = r_berrL;
  assign Busy_H     = (r_state != IDLE);

endmodule : bus_cycle_responder
`default_nettype wire

// File: tb/tb_bus_cycle_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_cycle_responder
// Description : Self-checking bench for bus_cycle_responder with default
//               parameters (ROM 0, RAM 1, IO 3 wait states, timeout 255).
//               Latency is counted in rising edges from the start edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_cycle_responder;

  localparam int LIMIT = 300;

  logic Clock = 1'b0;
  logic Reset_L;
  logic AS_L;
  logic UDS_L;
  logic LDS_L;
  logic OnChipRomSelect_H;
  logic OnChipRamSelect_H;
  logic IOSelect_H;
  logic DramSelect_H;
  logic DramDtack_L;
  logic DtackOut_L;
  logic BErr_L;
  logic Busy_H;

  bus_cycle_responder dut (
    .Clock             (Clock),
    .Reset_L           (Reset_L),
    .AS_L              (AS_L),
    .UDS_L             (UDS_L),
    .LDS_L             (LDS_L),
    .OnChipRomSelect_H (OnChipRomSelect_H),
    .OnChipRamSelect_H (OnChipRamSelect_H),
    .IOSelect_H        (IOSelect_H),
    .DramSelect_H      (DramSelect_H),
    .DramDtack_L       (DramDtack_L),
    .DtackOut_L        (DtackOut_L),
    .BErr_L            (BErr_L),
    .Busy_H            (Busy_H)
  );

  always #5 Clock = ~Clock;

  // dramDelay: -1 never, 0 already low at the start edge, k low from edge N+k.
  typedef struct {
    string name;
    logic  rom;
    logic  ram;
    logic  io;
    logic  dram;
    int    dramDelay;
    int    expLat;
    logic  expBerr;
  } vec_t;

  typedef struct {
    string name;
    int    lat;
    logic  berr;
  } exp_t;

  vec_t vecs[13];
  exp_t sb[$];
  int   nChecks = 0;
  int   nErrors = 0;

  task automatic check(input string name, input int got, input int exp);
    nChecks++;
    if (got != exp) begin
      nErrors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic deselect();
    OnChipRomSelect_H = 1'b0;
    OnChipRamSelect_H = 1'b0;
    IOSelect_H        = 1'b0;
    DramSelect_H      = 1'b0;
    DramDtack_L       = 1'b1;
    UDS_L             = 1'b1;
    LDS_L             = 1'b1;
  endtask

  task automatic runCycle(input vec_t v);
    exp_t e;
    int   lat;
    @(negedge Clock);
    OnChipRomSelect_H = v.rom;
    OnChipRamSelect_H = v.ram;
    IOSelect_H        = v.io;
    DramSelect_H      = v.dram;
    UDS_L             = 1'b0;
    LDS_L             = 1'b0;
    DramDtack_L       = (v.dramDelay == 0) ? 1'b0 : 1'b1;
    AS_L              = 1'b0;
    sb.push_back('{v.name, v.expLat, v.expBerr});
    @(posedge Clock); #1;
    check({v.name, " busy"}, int'(Busy_H), 1);
    lat = 0;
    while (DtackOut_L && BErr_L && (lat < LIMIT)) begin
      @(negedge Clock);
      if ((v.dramDelay >= 0) && (lat + 1 >= v.dramDelay)) DramDtack_L = 1'b0;
      @(posedge Clock); #1;
      lat++;
    end
    if (DtackOut_L && BErr_L) begin
      check({v.name, " response before limit"}, lat, v.expLat);
      void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      check({e.name, " latency"}, lat, e.lat);
      check({e.name, " berr"}, int'(!BErr_L), int'(e.berr));
      check({e.name, " dtack"}, int'(!DtackOut_L), int'(!e.berr));
    end
    // Response must persist while AS_L stays low.
    @(posedge Clock); #1;
    check({v.name, " held"}, int'({DtackOut_L, BErr_L}), int'({v.expBerr, !v.expBerr}));
    @(negedge Clock);
    AS_L = 1'b1;
    deselect();
    @(posedge Clock); #1;
    check({v.name, " release"}, int'({DtackOut_L, BErr_L, Busy_H}), 3'b110);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    Reset_L = 1'b0;
    AS_L    = 1'b1;
    deselect();

    vecs[0]  = '{"rom",             1'b1, 1'b0, 1'b0, 1'b0,  -1,   0, 1'b0};
    vecs[1]  = '{"ram",             1'b0, 1'b1, 1'b0, 1'b0,  -1,   1, 1'b0};
    vecs[2]  = '{"io",              1'b0, 1'b0, 1'b1, 1'b0,  -1,   3, 1'b0};
    vecs[3]  = '{"dram5",           1'b0, 1'b0, 1'b0, 1'b1,   5,   5, 1'b0};
    vecs[4]  = '{"ram_over_dram",   1'b0, 1'b1, 1'b0, 1'b1,   0,   1, 1'b0};
    vecs[5]  = '{"io_over_dram",    1'b0, 1'b0, 1'b1, 1'b1,   1,   3, 1'b0};
    vecs[6]  = '{"rom_over_io",     1'b1, 1'b0, 1'b1, 1'b0,  -1,   0, 1'b0};
    vecs[7]  = '{"dram_early",      1'b0, 1'b0, 1'b0, 1'b1,   0,   1, 1'b0};
    vecs[8]  = '{"ram_over_io",     1'b0, 1'b1, 1'b1, 1'b0,  -1,   1, 1'b0};
    vecs[9]  = '{"no_select",       1'b0, 1'b0, 1'b0, 1'b0,  -1, 255, 1'b1};
    vecs[10] = '{"dram_no_ack",     1'b0, 1'b0, 1'b0, 1'b1,  -1, 255, 1'b1};
    vecs[11] = '{"dram_at_timeout", 1'b0, 1'b0, 1'b0, 1'b1, 255, 255, 1'b0};
    vecs[12] = '{"dram_254",        1'b0, 1'b0, 1'b0, 1'b1, 254, 254, 1'b0};

    // Reset state.
    repeat (2) @(posedge Clock);
    #1;
    check("reset outputs", int'({DtackOut_L, BErr_L, Busy_H}), 3'b110);
    @(negedge Clock);
    Reset_L = 1'b1;
    repeat (2) @(posedge Clock);
    #1;
    check("idle after reset", int'({DtackOut_L, BErr_L, Busy_H}), 3'b110);

    // Table-driven cycles, back to back.
    for (int i = 0; i < 13; i++) runCycle(vecs[i]);

    // Aborted IO cycle: AS_L rises one edge after start.
    @(negedge Clock);
    IOSelect_H = 1'b1;
    AS_L       = 1'b0;
    @(posedge Clock); #1;
    check("abort busy at start", int'(Busy_H), 1);
    @(negedge Clock);
    AS_L = 1'b1;
    @(posedge Clock); #1;
    check("abort busy cleared", int'(Busy_H), 0);
    for (int i = 0; i < 5; i++) begin
      @(posedge Clock); #1;
      check("abort no response", int'({DtackOut_L, BErr_L}), 2'b11);
    end
    @(negedge Clock);
    deselect();

    // Reset during ACK with AS_L held low.
    @(negedge Clock);
    OnChipRomSelect_H = 1'b1;
    AS_L              = 1'b0;
    @(posedge Clock); #1;
    check("pre-reset ack", int'(DtackOut_L), 0);
    #2 Reset_L = 1'b0;
    #1;
    check("async reset outputs", int'({DtackOut_L, BErr_L, Busy_H}), 3'b110);
    @(negedge Clock);
    Reset_L = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge Clock); #1;
      check("held AS ignored", int'({DtackOut_L, Busy_H}), 2'b10);
    end
    @(negedge Clock);
    AS_L = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    AS_L = 1'b0;
    @(posedge Clock); #1;
    check("new cycle after reset", int'(DtackOut_L), 0);
    @(negedge Clock);
    AS_L = 1'b1;
    deselect();
    @(posedge Clock); #1;
    check("final release", int'({DtackOut_L, BErr_L, Busy_H}), 3'b110);

    check("scoreboard empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule : tb_bus_cycle_responder
`default_nettype wire
